edge_gradient_h: RTL and testbench

Horizontal edge-gradient stage of the edge detect filter. It sits directly upstream of the 24-bit-to-12-bit output scaler. It takes 12-bit RGB pixels on an Avalon-ST sink and converts each to 4-bit grey. For every pixel it computes the thresholded central-difference magnitude along the line and emits it on a 24-bit Avalon-ST source, with the magnitude replicated into the low nibble of every byte lane.

---
 rtl/edge_gradient_h.sv | 159 +++++++++++++++
 tb/tb_edge_gradient_h.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_gradient_h.sv
// Horizontal edge-gradient stage: RGB444 -> 4-bit grey, thresholded central
// difference along the line, replicated into the low nibble of each byte lane.
module edge_gradient_h #(
  parameter int unsigned IMG_WIDTH = 640,
  parameter logic [3:0]  THRESH    = 4'd2
) (
  input  logic        clock_clk,
  input  logic        reset,
  input  logic [11:0] data_in,
  input  logic        sop_in,
  input  logic        eop_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [23:0] data_out,
  output logic        sop_out,
  output logic        eop_out,
  output logic        valid_out,
  input  logic        ready_in
);

  localparam int unsigned COL_W = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       prev, prev_nxt;
  logic [3:0]       cur, cur_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic             sop_pend, sop_pend_nxt;
  logic             eop_pend, eop_pend_nxt;
  logic [23:0]      data_nxt;
  logic             sop_nxt, eop_nxt, valid_nxt;

  logic             out_free;
  logic             accept;
  logic [3:0]       grey;

  // (R + 2G + B) / 4 on a 6-bit sum
  function automatic logic [3:0] to_grey(input logic [11:0] px);
    logic [5:0] sum;
    sum = 6'(px[11:8]) + 6'({px[7:4], 1'b0}) + 6'(px[3:0]);
    return sum[5:2];
  endfunction

  // |a - b| with small magnitudes suppressed
  function automatic logic [3:0] grad(input logic [3:0] a, input logic [3:0] b);
    logic signed [4:0] diff;
    logic signed [4:0] absd;
    logic [3:0]        m;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    absd = diff[4] ? -diff : diff;
    m    = absd[3:0];
    return (m < THRESH) ? 4'd0 : m;
  endfunction

  function automatic logic [23:0] lanes(input logic [3:0] m);
    return {4'h0, m, 4'h0, m, 4'h0, m};
  endfunction

  assign out_free  = !valid_out || ready_in;
  assign ready_out = !reset && (state != FLUSH) && out_free;
  assign accept    = valid_in && ready_out;
  assign grey      = to_grey(data_in);

  // State and datapath registers
  always_ff @(posedge clock_clk) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= 4'd0;
      cur       <= 4'd0;
      col       <= '0;
      sop_pend  <= 1'b0;
      eop_pend  <= 1'b0;
      data_out  <= 24'd0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      cur       <= cur_nxt;
      col       <= col_nxt;
      sop_pend  <= sop_pend_nxt;
      eop_pend  <= eop_pend_nxt;
      data_out  <= data_nxt;
      sop_out   <= sop_nxt;
      eop_out   <= eop_nxt;
      valid_out <= valid_nxt;
    end
  end

  // Next-state, line tracking and output-beat generation
  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev;
    cur_nxt      = cur;
    col_nxt      = col;
    sop_pend_nxt = sop_pend;
    eop_pend_nxt = eop_pend;
    data_nxt     = data_out;
    sop_nxt      = sop_out;
    eop_nxt      = eop_out;
    valid_nxt    = valid_out && !ready_in;

    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          if ((col == '0) || sop_in) begin
            // first pixel of a line; a mid-line sop discards the held pixel
            prev_nxt     = grey;
            cur_nxt      = grey;
            sop_pend_nxt = sop_in;
            eop_pend_nxt = eop_in;
            if (eop_in) begin
              col_nxt   = '0;
              state_nxt = FLUSH;
            end else begin
              col_nxt   = COL_W'(1);
              state_nxt = HOLD;
            end
          end else begin
            data_nxt     = lanes(grad(grey, prev));
            sop_nxt      = sop_pend;
            eop_nxt      = 1'b0;
            valid_nxt    = 1'b1;
            sop_pend_nxt = 1'b0;
            prev_nxt     = cur;
            cur_nxt      = grey;
            if ((col == LAST_COL) || eop_in) begin
              eop_pend_nxt = eop_in;
              col_nxt      = '0;
              state_nxt    = FLUSH;
            end else begin
              col_nxt = col + COL_W'(1);
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          data_nxt     = lanes(grad(cur, prev));
          sop_nxt      = sop_pend;
          eop_nxt      = eop_pend;
          valid_nxt    = 1'b1;
          sop_pend_nxt = 1'b0;
          eop_pend_nxt = 1'b0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_edge_gradient_h.sv
// Scoreboard bench for edge_gradient_h (IMG_WIDTH = 4, THRESH = 2).
module tb_edge_gradient_h;

  logic        clk;
  logic        reset;
  logic [11:0] data_in;
  logic        sop_in;
  logic        eop_in;
  logic        valid_in;
  logic        ready_out;
  logic [23:0] data_out;
  logic        sop_out;
  logic        eop_out;
  logic        valid_out;
  logic        ready_in;

  int checks;
  int errors;
  logic [25:0] exp_q[$];

  edge_gradient_h #(
    .IMG_WIDTH(4),
    .THRESH   (4'd2)
  ) dut (
    .clock_clk(clk),
    .reset    (reset),
    .data_in  (data_in),
    .sop_in   (sop_in),
    .eop_in   (eop_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .sop_out  (sop_out),
    .eop_out  (eop_out),
    .valid_out(valid_out),
    .ready_in (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] beat(input logic [3:0] m, input logic s, input logic e);
    return {s, e, 4'h0, m, 4'h0, m, 4'h0, m};
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic [3:0] m, input logic s, input logic e);
    exp_q.push_back(beat(m, s, e));
  endtask

  // Present one pixel and hold it until accepted; returns stall cycles
  task automatic send(input logic [11:0] px, input logic s, input logic e, output int waits);
    logic acc;
    data_in  = px;
    sop_in   = s;
    eop_in   = e;
    valid_in = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      acc = ready_out;
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 40) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=%0d cycles required=accept", waits);
        break;
      end
    end
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
  endtask

  initial begin
    int w;
    int n;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 12'hFFF;
    sop_in   = 1'b1;
    eop_in   = 1'b0;
    ready_in = 1'b1;

    // Monitor: pop and compare on every transferred output beat
    fork
      forever begin
        @(negedge clk);
        if (valid_out && ready_in) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%h required=none", {sop_out, eop_out, data_out});
          end else begin
            check("beat", {sop_out, eop_out, data_out}, exp_q.pop_front());
          end
        end
      end
    join_none

    // Reset with valid_in high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", 26'(ready_out), 26'(0));
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    valid_in = 1'b0;
    sop_in   = 1'b0;
    @(negedge clk);
    check("rst_valid", 26'(valid_out), 26'(0));
    check("rst_data", 26'(data_out), 26'(0));
    check("rst_flags", 26'({sop_out, eop_out}), 26'(0));
    check("idle_ready", 26'(ready_out), 26'(1));
    @(posedge clk);
    #1;

    // Basic line: greys 0,15,0,15
    send(12'h000, 1'b1, 1'b0, w);
    expect_beat(4'd15, 1'b1, 1'b0);
    send(12'hFFF, 1'b0, 1'b0, w);
    expect_beat(4'd0, 1'b0, 1'b0);
    send(12'h000, 1'b0, 1'b0, w);
    expect_beat(4'd0, 1'b0, 1'b0);
    expect_beat(4'd15, 1'b0, 1'b1);
    send(12'hFFF, 1'b0, 1'b1, w);
    @(negedge clk);
    check("flush_ready_low", 26'(ready_out), 26'(0));
    @(posedge clk);
    #1;

    // Back-to-back frame, greys 0,2,2,0 (mag exactly THRESH), stalled mid-line
    send(12'h000, 1'b1, 1'b0, w);
    check("b2b_no_bubble", 26'(w), 26'(0));
    expect_beat(4'd2, 1'b1, 1'b0);
    send(12'h222, 1'b0, 1'b0, w);
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 26'(valid_out), 26'(1));
      check("stall_beat", {sop_out, eop_out, data_out}, beat(4'd2, 1'b1, 1'b0));
      check("stall_ready", 26'(ready_out), 26'(0));
      @(posedge clk);
      #1;
    end
    ready_in = 1'b1;
    expect_beat(4'd2, 1'b0, 1'b0);
    send(12'h222, 1'b0, 1'b0, w);
    expect_beat(4'd2, 1'b0, 1'b0);
    expect_beat(4'd2, 1'b0, 1'b1);
    send(12'h000, 1'b0, 1'b1, w);

    // Early eop: greys 0,15
    send(12'h000, 1'b1, 1'b0, w);
    expect_beat(4'd15, 1'b1, 1'b0);
    expect_beat(4'd15, 1'b0, 1'b1);
    send(12'hFFF, 1'b0, 1'b1, w);

    // Threshold line: greys 0,1,3,4 -> raw 1,3,3,1
    send(12'h000, 1'b1, 1'b0, w);
    expect_beat(4'd0, 1'b1, 1'b0);
    send(12'h111, 1'b0, 1'b0, w);
    expect_beat(4'd3, 1'b0, 1'b0);
    send(12'h333, 1'b0, 1'b0, w);
    expect_beat(4'd3, 1'b0, 1'b0);
    expect_beat(4'd0, 1'b0, 1'b1);
    send(12'h444, 1'b0, 1'b1, w);

    // Abort: sop at col 2 drops the held pixel; new frame greys 4,0,15,15
    send(12'h000, 1'b1, 1'b0, w);
    expect_beat(4'd15, 1'b1, 1'b0);
    send(12'hFFF, 1'b0, 1'b0, w);
    send(12'h444, 1'b1, 1'b0, w);
    expect_beat(4'd4, 1'b1, 1'b0);
    send(12'h000, 1'b0, 1'b0, w);
    expect_beat(4'd11, 1'b0, 1'b0);
    send(12'hFFF, 1'b0, 1'b0, w);
    expect_beat(4'd15, 1'b0, 1'b0);
    expect_beat(4'd0, 1'b0, 1'b1);
    send(12'hFFF, 1'b0, 1'b1, w);

    // Reset mid-line: no beats until fresh input
    send(12'hFFF, 1'b1, 1'b0, w);
    expect_beat(4'd15, 1'b1, 1'b0);
    send(12'h000, 1'b0, 1'b0, w);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_ready", 26'(ready_out), 26'(0));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single pixel with sop and eop together
    expect_beat(4'd0, 1'b1, 1'b1);
    send(12'hFFF, 1'b1, 1'b1, w);

    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain", 26'(exp_q.size()), 26'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
